// File: rtl/nvdla_package.sv
// Shared definitions for the NVDLA DBB AXI adapter.
// Holds the adapter FSM state encoding and the default interface widths
// used as parameter defaults by nvdla_dbb_axi_adapter.
package nvdla_package;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRESP = 3'd3,
    ST_RDATA = 3'd4
  } state_dbb_axi_fsm_t;

  localparam int unsigned DBB_ADDR_W    = 32'd32;
  localparam int unsigned DBB_DATA_W    = 32'd32;
  localparam int unsigned DBB_ID_W      = 32'd8;
  localparam int unsigned DBB_LEN_W     = 32'd4;
  localparam int unsigned DBB_REQ_DEPTH = 32'd2;

endpackage

// File: rtl/nvdla_dbb_req_fifo.sv
// Small synchronous FIFO buffering AXI address requests.
// Ports:
//   clk_i, rst_ni (async active-low), clear_i (sync flush)
//   push_i/data_i/ready_o : write side, push accepted only while ready_o
//   pop_i/data_o/empty_o  : read side, data_o is the head entry
// ready_o is registered: it is low during reset, rises one cycle after
// release, and stays low while full (a pop cannot free room for a push
// in the same cycle).
module nvdla_dbb_req_fifo #(
  parameter int unsigned DEPTH = 32'd2,
  parameter int unsigned WIDTH = 32'd8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = (PTR_W)'(32'd1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   count_next_s;
  logic             ready_r;
  logic             push_s;
  logic             pop_s;

  assign push_s  = push_i & ready_r;
  assign pop_s   = pop_i & ~empty_o;
  assign empty_o = (count_r == {(PTR_W+1){1'b0}});
  assign ready_o = ready_r;
  assign data_o  = mem_r[rd_ptr_r];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next_s = count_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
  end

  // Pointers, occupancy and registered ready
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      ready_r  <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      ready_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      ready_r <= (count_next_s != FULL_CNT);
    end
  end

  // Entry storage; contents are only meaningful behind the pointers, so no reset
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

endmodule

// File: rtl/nvdla_dbb_axi_adapter.sv
// NVDLA DBB AXI-style slave adapter.
// Terminates AW/W/B and AR/R, buffers address requests in two FIFOs,
// arbitrates reads against writes round-robin and presents one transaction
// at a time on a flat req / wd / wr / rd interface.
// Ports:
//   clk_i, rst_ni (async active-low), clear_i (sync clear of everything)
//   aw_* / w_* / b_*    : AXI write address, data, response
//   ar_* / r_*          : AXI read address, data
//   req_*               : downstream request, req_len_o in beats (len+1)
//   wd_* / wr_* / rd_*  : downstream write data, write response, read data
//   busy_o              : a transaction is in flight
//   err_o               : sticky protocol error
// Build option: define NVDLA_DBB_ERR_CHECK_EN to enable protocol checking
// (beat count vs. last flag, response IDs); otherwise err_o is tied low.
module nvdla_dbb_axi_adapter
  import nvdla_package::*;
#(
  parameter int unsigned ADDR_W    = DBB_ADDR_W,
  parameter int unsigned DATA_W    = DBB_DATA_W,
  parameter int unsigned ID_W      = DBB_ID_W,
  parameter int unsigned LEN_W     = DBB_LEN_W,
  parameter int unsigned REQ_DEPTH = DBB_REQ_DEPTH
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                aw_valid_i,
  output logic                aw_ready_o,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  input  logic [ID_W-1:0]     aw_id_i,
  input  logic [LEN_W-1:0]    aw_len_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  input  logic                w_last_i,
  output logic                b_valid_o,
  input  logic                b_ready_i,
  output logic [ID_W-1:0]     b_id_o,
  input  logic                ar_valid_i,
  output logic                ar_ready_o,
  input  logic [ADDR_W-1:0]   ar_addr_i,
  input  logic [ID_W-1:0]     ar_id_i,
  input  logic [LEN_W-1:0]    ar_len_i,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  output logic [DATA_W-1:0]   r_data_o,
  output logic [ID_W-1:0]     r_id_o,
  output logic                r_last_o,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  output logic                req_write_o,
  output logic [ADDR_W-1:0]   req_addr_o,
  output logic [ID_W-1:0]     req_id_o,
  output logic [LEN_W:0]      req_len_o,
  output logic                wd_valid_o,
  input  logic                wd_ready_i,
  output logic [DATA_W-1:0]   wd_data_o,
  output logic [DATA_W/8-1:0] wd_strb_o,
  output logic                wd_last_o,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [ID_W-1:0]     wr_id_i,
  input  logic                rd_valid_i,
  output logic                rd_ready_o,
  input  logic [DATA_W-1:0]   rd_data_i,
  input  logic [ID_W-1:0]     rd_id_i,
  input  logic                rd_last_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned    REQ_W    = ADDR_W + ID_W + LEN_W;
  localparam logic [LEN_W:0] ONE_BEAT = (LEN_W+1)'(32'd1);

  state_dbb_axi_fsm_t state_r;
  logic               prio_write_r;
  logic               req_valid_r;
  logic               req_write_r;
  logic [ADDR_W-1:0]  req_addr_r;
  logic [ID_W-1:0]    req_id_r;
  logic [LEN_W:0]     req_len_r;

  logic [REQ_W-1:0]   aw_head_s;
  logic [REQ_W-1:0]   ar_head_s;
  logic [REQ_W-1:0]   head_s;
  logic               aw_empty_s;
  logic               ar_empty_s;
  logic               grant_w_s;
  logic               grant_r_s;
  logic               in_wdata_s;
  logic               in_wresp_s;
  logic               in_rdata_s;
  logic               w_hs_s;
  logic               b_hs_s;
  logic               r_hs_s;

  nvdla_dbb_req_fifo #(.DEPTH(REQ_DEPTH), .WIDTH(REQ_W)) u_aw_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (aw_valid_i),
    .data_i  ({aw_addr_i, aw_id_i, aw_len_i}),
    .ready_o (aw_ready_o),
    .pop_i   (grant_w_s),
    .data_o  (aw_head_s),
    .empty_o (aw_empty_s)
  );

  nvdla_dbb_req_fifo #(.DEPTH(REQ_DEPTH), .WIDTH(REQ_W)) u_ar_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (ar_valid_i),
    .data_i  ({ar_addr_i, ar_id_i, ar_len_i}),
    .ready_o (ar_ready_o),
    .pop_i   (grant_r_s),
    .data_o  (ar_head_s),
    .empty_o (ar_empty_s)
  );

  // Round-robin pick between the address FIFOs; a lone non-empty FIFO always wins
  always_comb begin
    grant_w_s = 1'b0;
    grant_r_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (!aw_empty_s && (ar_empty_s || prio_write_r)) begin
        grant_w_s = 1'b1;
      end else if (!ar_empty_s) begin
        grant_r_s = 1'b1;
      end else begin
        grant_w_s = 1'b0;
      end
    end else begin
      grant_r_s = 1'b0;
    end
  end

  assign head_s     = grant_w_s ? aw_head_s : ar_head_s;
  assign in_wdata_s = (state_r == ST_WDATA);
  assign in_wresp_s = (state_r == ST_WRESP);
  assign in_rdata_s = (state_r == ST_RDATA);
  assign w_hs_s     = in_wdata_s & w_valid_i & wd_ready_i;
  assign b_hs_s     = in_wresp_s & wr_valid_i & b_ready_i;
  assign r_hs_s     = in_rdata_s & rd_valid_i & r_ready_i;

  // Transaction FSM with the registered request fields
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      prio_write_r <= 1'b1;
      req_valid_r  <= 1'b0;
      req_write_r  <= 1'b0;
      req_addr_r   <= {ADDR_W{1'b0}};
      req_id_r     <= {ID_W{1'b0}};
      req_len_r    <= {(LEN_W+1){1'b0}};
    end else if (clear_i) begin
      state_r      <= ST_IDLE;
      prio_write_r <= 1'b1;
      req_valid_r  <= 1'b0;
      req_write_r  <= 1'b0;
      req_addr_r   <= {ADDR_W{1'b0}};
      req_id_r     <= {ID_W{1'b0}};
      req_len_r    <= {(LEN_W+1){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_w_s || grant_r_s) begin
            req_valid_r  <= 1'b1;
            req_write_r  <= grant_w_s;
            req_addr_r   <= head_s[REQ_W-1 -: ADDR_W];
            req_id_r     <= head_s[LEN_W +: ID_W];
            req_len_r    <= {1'b0, head_s[LEN_W-1:0]} + ONE_BEAT;
            // Next grant favours the other transaction type
            prio_write_r <= grant_r_s;
            state_r      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (req_ready_i) begin
            req_valid_r <= 1'b0;
            state_r     <= req_write_r ? ST_WDATA : ST_RDATA;
          end
        end
        ST_WDATA: begin
          if (w_hs_s && w_last_i) begin
            state_r <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (b_hs_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_RDATA: begin
          if (r_hs_s && rd_last_i) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_valid_o = req_valid_r;
  assign req_write_o = req_write_r;
  assign req_addr_o  = req_addr_r;
  assign req_id_o    = req_id_r;
  assign req_len_o   = req_len_r;
  assign busy_o      = (state_r != ST_IDLE);

  // Data and response paths are pure pass-through, gated by the FSM state
  assign wd_valid_o = in_wdata_s & w_valid_i;
  assign w_ready_o  = in_wdata_s & wd_ready_i;
  assign wd_data_o  = w_data_i;
  assign wd_strb_o  = w_strb_i;
  assign wd_last_o  = w_last_i;
  assign b_valid_o  = in_wresp_s & wr_valid_i;
  assign wr_ready_o = in_wresp_s & b_ready_i;
  assign b_id_o     = wr_id_i;
  assign r_valid_o  = in_rdata_s & rd_valid_i;
  assign rd_ready_o = in_rdata_s & r_ready_i;
  assign r_data_o   = rd_data_i;
  assign r_id_o     = rd_id_i;
  assign r_last_o   = rd_last_i;

`ifdef NVDLA_DBB_ERR_CHECK_EN
  logic [LEN_W:0] beat_cnt_r;
  logic [LEN_W:0] last_idx_s;
  logic           err_r;

  assign last_idx_s = req_len_r - ONE_BEAT;

  // Beat counter and sticky protocol error; the transaction still ends on the last flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_r <= {(LEN_W+1){1'b0}};
      err_r      <= 1'b0;
    end else if (clear_i) begin
      beat_cnt_r <= {(LEN_W+1){1'b0}};
      err_r      <= 1'b0;
    end else begin
      if ((state_r == ST_REQ) && req_ready_i) begin
        beat_cnt_r <= {(LEN_W+1){1'b0}};
      end else if (w_hs_s || r_hs_s) begin
        beat_cnt_r <= beat_cnt_r + ONE_BEAT;
      end
      if (w_hs_s && (w_last_i != (beat_cnt_r == last_idx_s))) begin
        err_r <= 1'b1;
      end
      if (b_hs_s && (wr_id_i != req_id_r)) begin
        err_r <= 1'b1;
      end
      if (r_hs_s && ((rd_id_i != req_id_r) || (rd_last_i && (beat_cnt_r != last_idx_s)))) begin
        err_r <= 1'b1;
      end
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_nvdla_dbb_axi_adapter.sv
// Self-checking bench for nvdla_dbb_axi_adapter: a table of single
// transactions plus hand-written sequences for arbitration, FIFO full,
// clear and the early-last error case. Expected downstream/AXI traffic is
// queued when stimulus is driven and compared by a negedge monitor.
module tb_nvdla_dbb_axi_adapter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        aw_valid_i, aw_ready_o;
  logic [31:0] aw_addr_i;
  logic [7:0]  aw_id_i;
  logic [3:0]  aw_len_i;
  logic        w_valid_i, w_ready_o, w_last_i;
  logic [31:0] w_data_i;
  logic [3:0]  w_strb_i;
  logic        b_valid_o, b_ready_i;
  logic [7:0]  b_id_o;
  logic        ar_valid_i, ar_ready_o;
  logic [31:0] ar_addr_i;
  logic [7:0]  ar_id_i;
  logic [3:0]  ar_len_i;
  logic        r_valid_o, r_ready_i, r_last_o;
  logic [31:0] r_data_o;
  logic [7:0]  r_id_o;
  logic        req_valid_o, req_ready_i, req_write_o;
  logic [31:0] req_addr_o;
  logic [7:0]  req_id_o;
  logic [4:0]  req_len_o;
  logic        wd_valid_o, wd_ready_i, wd_last_o;
  logic [31:0] wd_data_o;
  logic [3:0]  wd_strb_o;
  logic        wr_valid_i, wr_ready_o;
  logic [7:0]  wr_id_i;
  logic        rd_valid_i, rd_ready_o, rd_last_i;
  logic [31:0] rd_data_i;
  logic [7:0]  rd_id_i;
  logic        busy_o, err_o;

`ifdef NVDLA_DBB_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  nvdla_dbb_axi_adapter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
    .aw_id_i(aw_id_i), .aw_len_i(aw_len_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_id_i(ar_id_i), .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
    .r_id_o(r_id_o), .r_last_o(r_last_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_write_o(req_write_o),
    .req_addr_o(req_addr_o), .req_id_o(req_id_o), .req_len_o(req_len_o),
    .wd_valid_o(wd_valid_o), .wd_ready_i(wd_ready_i), .wd_data_o(wd_data_o),
    .wd_strb_o(wd_strb_o), .wd_last_o(wd_last_o),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_id_i(wr_id_i),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_data_i(rd_data_i),
    .rd_id_i(rd_id_i), .rd_last_i(rd_last_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct packed {logic wr; logic [31:0] addr; logic [7:0] id; logic [4:0] len;} req_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} wd_t;
  typedef struct packed {logic [31:0] data; logic [7:0] id; logic last;} rb_t;
  typedef struct {logic wr; logic [31:0] addr; logic [7:0] id; logic [3:0] len; logic [4:0] exp_len;} vec_t;

  req_t       exp_req[$];
  wd_t        exp_wd[$];
  logic [7:0] exp_b[$];
  rb_t        exp_r[$];
  req_t       mon_req;
  wd_t        mon_wd;
  logic [7:0] mon_b;
  rb_t        mon_r;
  vec_t       tbl[6];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, 64'(act), 64'(exp));
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen/timed out, expected otherwise", name);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic rdy(input int which);
    case (which)
      0: return aw_ready_o;
      1: return ar_ready_o;
      2: return w_ready_o;
      3: return wr_ready_o;
      4: return rd_ready_o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_rdy(input int which, input string name);
    int n;
    n = 0;
    while (!rdy(which) && n < 100) begin
      tick();
      n++;
    end
    if (!rdy(which)) note_fail(name);
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [7:0] id, input logic [3:0] len);
    aw_valid_i = 1'b1; aw_addr_i = a; aw_id_i = id; aw_len_i = len;
    wait_rdy(0, "aw_ready_timeout");
    tick();
    aw_valid_i = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] id, input logic [3:0] len);
    ar_valid_i = 1'b1; ar_addr_i = a; ar_id_i = id; ar_len_i = len;
    wait_rdy(1, "ar_ready_timeout");
    tick();
    ar_valid_i = 1'b0;
  endtask

  task automatic send_w(input int n, input logic [31:0] base, input int last_at);
    for (int i = 0; i < n; i++) begin
      w_valid_i = 1'b1;
      w_data_i  = base + 32'(i);
      w_strb_i  = 4'(i + 1);
      w_last_i  = (i == last_at);
      exp_wd.push_back({w_data_i, w_strb_i, w_last_i});
      wait_rdy(2, "w_ready_timeout");
      tick();
    end
    w_valid_i = 1'b0;
    w_last_i  = 1'b0;
  endtask

  task automatic send_wr(input logic [7:0] id);
    wr_valid_i = 1'b1;
    wr_id_i    = id;
    exp_b.push_back(id);
    wait_rdy(3, "wr_ready_timeout");
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic send_rd(input int n, input logic [31:0] base, input logic [7:0] id);
    for (int i = 0; i < n; i++) begin
      rd_valid_i = 1'b1;
      rd_data_i  = base + 32'(i);
      rd_id_i    = id;
      rd_last_i  = (i == n - 1);
      exp_r.push_back({rd_data_i, rd_id_i, rd_last_i});
      wait_rdy(4, "rd_ready_timeout");
      tick();
    end
    rd_valid_i = 1'b0;
    rd_last_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
  endtask

  // Scoreboard monitor: compare every handshake against the queued expectation
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (req_valid_o && req_ready_i) begin
        if (exp_req.size() == 0) note_fail("req_unexpected");
        else begin
          mon_req = exp_req.pop_front();
          check("req", 64'({req_write_o, req_addr_o, req_id_o, req_len_o}), 64'(mon_req));
        end
      end
      if (wd_valid_o && wd_ready_i) begin
        if (exp_wd.size() == 0) note_fail("wd_unexpected");
        else begin
          mon_wd = exp_wd.pop_front();
          check("wd", 64'({wd_data_o, wd_strb_o, wd_last_o}), 64'(mon_wd));
        end
      end
      if (b_valid_o && b_ready_i) begin
        if (exp_b.size() == 0) note_fail("b_unexpected");
        else begin
          mon_b = exp_b.pop_front();
          check("b_id", 64'(b_id_o), 64'(mon_b));
        end
      end
      if (r_valid_o && r_ready_i) begin
        if (exp_r.size() == 0) note_fail("r_unexpected");
        else begin
          mon_r = exp_r.pop_front();
          check("r", 64'({r_data_o, r_id_o, r_last_o}), 64'(mon_r));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0;
    aw_valid_i = 1'b0; aw_addr_i = 32'h0; aw_id_i = 8'h0; aw_len_i = 4'h0;
    ar_valid_i = 1'b0; ar_addr_i = 32'h0; ar_id_i = 8'h0; ar_len_i = 4'h0;
    w_valid_i = 1'b0; w_data_i = 32'h0; w_strb_i = 4'h0; w_last_i = 1'b0;
    wr_valid_i = 1'b0; wr_id_i = 8'h0;
    rd_valid_i = 1'b0; rd_data_i = 32'h0; rd_id_i = 8'h0; rd_last_i = 1'b0;
    req_ready_i = 1'b1; wd_ready_i = 1'b1; b_ready_i = 1'b1; r_ready_i = 1'b1;

    tbl[0] = '{1'b1, 32'h1000_0000, 8'h12, 4'd3,  5'd4};
    tbl[1] = '{1'b0, 32'h1000_0100, 8'h21, 4'd0,  5'd1};
    tbl[2] = '{1'b1, 32'h1000_0200, 8'h03, 4'd0,  5'd1};
    tbl[3] = '{1'b0, 32'h1000_0300, 8'hA5, 4'd15, 5'd16};
    tbl[4] = '{1'b1, 32'hFFFF_FFFC, 8'hFF, 4'd15, 5'd16};
    tbl[5] = '{1'b0, 32'h0000_0004, 8'h00, 4'd2,  5'd3};

    // Reset state
    repeat (2) tick();
    chk1("rst_aw_ready", aw_ready_o, 1'b0);
    chk1("rst_ar_ready", ar_ready_o, 1'b0);
    chk1("rst_req_valid", req_valid_o, 1'b0);
    chk1("rst_wr_ready", wr_ready_o, 1'b0);
    chk1("rst_rd_ready", rd_ready_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    check("rst_req_fields", 64'({req_write_o, req_addr_o, req_id_o, req_len_o}), 64'h0);
    rst_ni = 1'b1;
    chk1("aw_ready_at_release", aw_ready_o, 1'b0);
    tick();
    chk1("aw_ready_after_release", aw_ready_o, 1'b1);
    chk1("ar_ready_after_release", ar_ready_o, 1'b1);

    // Table of single transactions
    for (int k = 0; k < 6; k++) begin
      exp_req.push_back({tbl[k].wr, tbl[k].addr, tbl[k].id, tbl[k].exp_len});
      if (tbl[k].wr) send_aw(tbl[k].addr, tbl[k].id, tbl[k].len);
      else send_ar(tbl[k].addr, tbl[k].id, tbl[k].len);
      chk1("req_valid_cycle1", req_valid_o, 1'b0);
      tick();
      chk1("req_valid_cycle2", req_valid_o, 1'b1);
      if (tbl[k].wr) begin
        send_w(int'(tbl[k].exp_len), 32'hD000_0000 + 32'(k * 256), int'(tbl[k].len));
        send_wr(tbl[k].id);
      end else begin
        send_rd(int'(tbl[k].exp_len), 32'hC000_0000 + 32'(k * 256), tbl[k].id);
      end
      chk1("busy_after_txn", busy_o, 1'b0);
      chk1("err_after_txn", err_o, 1'b0);
    end

    // Early w_last: last flag on beat 2 of a 4-beat write
    exp_req.push_back({1'b1, 32'h2000_0000, 8'h33, 5'd4});
    send_aw(32'h2000_0000, 8'h33, 4'd3);
    send_w(3, 32'hE000_0000, 2);
    chk1("early_last_wresp_busy", busy_o, 1'b1);
    chk1("early_last_no_w_ready", w_ready_o, 1'b0);
    chk1("early_last_err", err_o, EXP_ERR);
    send_wr(8'h33);
    chk1("early_last_idle", busy_o, 1'b0);
    chk1("err_sticky", err_o, EXP_ERR);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk1("err_cleared", err_o, 1'b0);

    // clear_i in the middle of a write burst, with another AW queued
    exp_req.push_back({1'b1, 32'h3000_0000, 8'h44, 5'd4});
    send_aw(32'h3000_0000, 8'h44, 4'd3);
    send_w(1, 32'hB000_0000, 9);
    send_aw(32'h3100_0000, 8'h45, 4'd0);
    chk1("busy_before_clear", busy_o, 1'b1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk1("busy_after_clear", busy_o, 1'b0);
    chk1("aw_ready_after_clear", aw_ready_o, 1'b1);
    wr_valid_i = 1'b1;
    wr_id_i    = 8'h44;
    for (int i = 0; i < 3; i++) begin
      chk1("no_b_after_clear", b_valid_o, 1'b0);
      chk1("no_req_after_clear", req_valid_o, 1'b0);
      tick();
    end
    wr_valid_i = 1'b0;

    // AW and AR in the same cycle straight out of reset: write first
    do_reset();
    exp_req.push_back({1'b1, 32'h4000_0000, 8'h51, 5'd2});
    exp_req.push_back({1'b0, 32'h5000_0000, 8'h52, 5'd1});
    aw_valid_i = 1'b1; aw_addr_i = 32'h4000_0000; aw_id_i = 8'h51; aw_len_i = 4'd1;
    ar_valid_i = 1'b1; ar_addr_i = 32'h5000_0000; ar_id_i = 8'h52; ar_len_i = 4'd0;
    chk1("both_ready", aw_ready_o & ar_ready_o, 1'b1);
    tick();
    aw_valid_i = 1'b0;
    ar_valid_i = 1'b0;
    send_w(2, 32'hA000_0000, 1);
    send_wr(8'h51);
    send_rd(1, 32'h9000_0000, 8'h52);
    chk1("pair_done", busy_o, 1'b0);

    // FIFO full with the request stalled, then W,R,W,W ordering
    req_ready_i = 1'b0;
    exp_req.push_back({1'b1, 32'h6000_0000, 8'h61, 5'd1});
    exp_req.push_back({1'b0, 32'h7000_0000, 8'h71, 5'd2});
    exp_req.push_back({1'b1, 32'h6000_0010, 8'h62, 5'd1});
    exp_req.push_back({1'b1, 32'h6000_0020, 8'h63, 5'd1});
    send_aw(32'h6000_0000, 8'h61, 4'd0);
    send_aw(32'h6000_0010, 8'h62, 4'd0);
    chk1("aw_ready_one_entry", aw_ready_o, 1'b1);
    send_aw(32'h6000_0020, 8'h63, 4'd0);
    chk1("aw_ready_full", aw_ready_o, 1'b0);
    chk1("req_held", req_valid_o, 1'b1);
    check("req_addr_held", 64'(req_addr_o), 64'h6000_0000);
    send_ar(32'h7000_0000, 8'h71, 4'd1);
    req_ready_i = 1'b1;
    send_w(1, 32'h8000_0000, 0);
    send_wr(8'h61);
    chk1("b2b_gap", req_valid_o, 1'b0);
    tick();
    chk1("b2b_req", req_valid_o, 1'b1);
    send_rd(2, 32'h8100_0000, 8'h71);
    send_w(1, 32'h8200_0000, 0);
    send_wr(8'h62);
    send_w(1, 32'h8300_0000, 0);
    send_wr(8'h63);
    tick();
    chk1("final_idle", busy_o, 1'b0);
    check("exp_req_drained", 64'(exp_req.size()), 64'h0);
    check("exp_wd_drained", 64'(exp_wd.size()), 64'h0);
    check("exp_b_drained", 64'(exp_b.size()), 64'h0);
    check("exp_r_drained", 64'(exp_r.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
